// File: rtl/fft_sdf_stage_ctrl.sv
// rtl/fft_sdf_stage_ctrl.sv - Sequencer for one radix-2 SDF stage of the 16-lane parallel FFT.
// Optional stall watchdog enabled by defining FFT_SDF_STALL_CHK_EN.
module fft_sdf_stage_ctrl #(
  parameter int N         = 256,
  parameter int LANES     = 16,
  parameter int DLY       = N / (2 * LANES),
  parameter int STALL_MAX = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  output logic                 sr_valid,
  output logic                 bfly_en,
  output logic                 out_sel,
  output logic                 dout_valid,
  output logic [$clog2(DLY):0] tw_idx,
  output logic                 dout_last,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 err
);

  localparam int FB  = N / LANES;
  localparam int CW  = $clog2(FB);
  localparam int LOG = $clog2(DLY);
  localparam int TW  = LOG + 1;
  localparam logic [CW-1:0] BLK_LAST = CW'(FB - 1);
  localparam logic [CW-1:0] DLY_BLKS = CW'(DLY);
  localparam logic [TW-1:0] D_LAST   = TW'(DLY - 1);

  typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;

  state_t        state;
  state_t        acc_state;
  logic [CW-1:0] blk_cnt;
  logic [CW-1:0] blk_nxt;
  logic [TW-1:0] d_cnt;
  logic          pend;
  logic          ph_nxt;
  logic          d_end;
  logic          tail_last;
  logic          stall_abort;

  assign blk_nxt   = (blk_cnt == BLK_LAST) ? '0 : blk_cnt + 1'b1;
  assign ph_nxt    = blk_nxt[LOG];
  assign acc_state = ph_nxt ? BFLY : FILL;
  assign d_end     = (d_cnt == D_LAST);
  // Pending diffs seen in the first DLY blocks of a frame are the previous frame's tail.
  assign tail_last = d_end && (blk_cnt < DLY_BLKS);

  assign sr_valid = din_valid || (state == DRAIN);
  assign bfly_en  = (state == BFLY);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      blk_cnt    <= '0;
      d_cnt      <= '0;
      pend       <= 1'b0;
      dout_valid <= 1'b0;
      out_sel    <= 1'b0;
      tw_idx     <= '0;
      dout_last  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      out_sel    <= 1'b0;
      tw_idx     <= '0;
      dout_last  <= 1'b0;
      frame_done <= 1'b0;
      if (stall_abort) begin
        state   <= IDLE;
        blk_cnt <= '0;
        d_cnt   <= '0;
        pend    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (din_valid) begin
              blk_cnt <= blk_nxt;
              state   <= acc_state;
            end
          end
          FILL: begin
            if (din_valid) begin
              blk_cnt <= blk_nxt;
              state   <= acc_state;
              if (pend) begin
                dout_valid <= 1'b1;
                tw_idx     <= d_cnt;
                dout_last  <= tail_last;
                frame_done <= tail_last;
                d_cnt      <= d_end ? '0 : d_cnt + 1'b1;
                pend       <= !d_end;
              end
            end
          end
          BFLY: begin
            if (din_valid) begin
              dout_valid <= 1'b1;
              out_sel    <= 1'b1;
              blk_cnt    <= blk_nxt;
              if (blk_cnt == BLK_LAST) begin
                state <= DRAIN;
                d_cnt <= '0;
              end else if (!ph_nxt) begin
                state <= FILL;
                pend  <= 1'b1;
                d_cnt <= '0;
              end
            end
          end
          DRAIN: begin
            dout_valid <= 1'b1;
            tw_idx     <= d_cnt;
            dout_last  <= d_end;
            frame_done <= d_end;
            d_cnt      <= d_end ? '0 : d_cnt + 1'b1;
            // A new frame overlapping the drain keeps emitting the leftover diffs from FILL.
            if (din_valid) begin
              blk_cnt <= blk_nxt;
              state   <= acc_state;
              pend    <= !d_end;
            end else if (d_end) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FFT_SDF_STALL_CHK_EN
  localparam int SW = $clog2(STALL_MAX + 1);

  logic [SW-1:0] stall_cnt;
  logic          stalling;

  assign stalling    = ((state == FILL) || (state == BFLY)) && !din_valid;
  assign stall_abort = stalling && (stall_cnt == SW'(STALL_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else if (stall_abort) begin
      stall_cnt <= '0;
      err       <= 1'b1;
    end else if (stalling) begin
      stall_cnt <= stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end
`else
  assign stall_abort = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// tb/tb_fft_sdf_stage_ctrl.sv - Directed self-checking bench for fft_sdf_stage_ctrl (DLY=8 and DLY=1).
module tb_fft_sdf_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid;
  logic       din1;

  logic       sr_valid, bfly_en, out_sel, dout_valid, dout_last, frame_done, busy, err;
  logic [3:0] tw_idx;
  logic       sr1, bf1, os1, dv1, dl1, fd1, busy1, err1;
  logic [0:0] tw1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] obs;
  logic [8:0]  obs1;

  always #5 clk = ~clk;

  fft_sdf_stage_ctrl #(.N(256), .LANES(16), .DLY(8), .STALL_MAX(4)) u_dut (
    .clk(clk), .rst(rst), .din_valid(din_valid),
    .sr_valid(sr_valid), .bfly_en(bfly_en), .out_sel(out_sel), .dout_valid(dout_valid),
    .tw_idx(tw_idx), .dout_last(dout_last), .frame_done(frame_done), .busy(busy), .err(err)
  );

  fft_sdf_stage_ctrl #(.N(256), .LANES(16), .DLY(1), .STALL_MAX(4)) u_dut1 (
    .clk(clk), .rst(rst), .din_valid(din1),
    .sr_valid(sr1), .bfly_en(bf1), .out_sel(os1), .dout_valid(dv1),
    .tw_idx(tw1), .dout_last(dl1), .frame_done(fd1), .busy(busy1), .err(err1)
  );

  assign obs  = {sr_valid, bfly_en, dout_valid, out_sel, tw_idx, dout_last, frame_done, busy, err};
  assign obs1 = {sr1, bf1, dv1, os1, tw1, dl1, fd1, busy1, err1};

  task automatic step(input logic v, input logic r, input logic v1);
    @(posedge clk);
    #1;
    din_valid = v;
    rst       = r;
    din1      = v1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_main got=%b exp=%b", obs, 12'd0);
    end
    n_checks++;
    if (obs1 !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_dly1 got=%b exp=%b", obs1, 9'd0);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    logic [11:0] e;
    for (int c = 0; c < 27; c++) begin
      step(c < 16, 1'b0, 1'b0);
      e = {c <= 23, (c >= 8) && (c < 16), (c >= 9) && (c <= 24), (c >= 9) && (c <= 16),
           ((c >= 17) && (c <= 24)) ? 4'(c - 17) : 4'd0, c == 24, c == 24,
           (c >= 1) && (c <= 23), 1'b0};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL single c=%0d got=%b exp=%b", c, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    logic [3:0]  tw;
    int ndv = 0;
    int nfd = 0;
    for (int c = 0; c < 46; c++) begin
      step(c < 32, 1'b0, 1'b0);
      tw = ((c >= 17) && (c <= 24)) ? 4'(c - 17) : ((c >= 33) && (c <= 40)) ? 4'(c - 33) : 4'd0;
      e = {c <= 39, (c < 32) && ((c % 16) >= 8), (c >= 9) && (c <= 40),
           ((c >= 9) && (c <= 16)) || ((c >= 25) && (c <= 32)), tw,
           (c == 24) || (c == 40), (c == 24) || (c == 40), (c >= 1) && (c <= 39), 1'b0};
      ndv += int'(dout_valid);
      nfd += int'(frame_done);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL b2b c=%0d got=%b exp=%b", c, obs, e);
      end
    end
    n_checks++;
    if (ndv != 32) begin
      n_fail++;
      $display("FAIL b2b_dout_count got=%0d exp=32", ndv);
    end
    n_checks++;
    if (nfd != 2) begin
      n_fail++;
      $display("FAIL b2b_frame_done_count got=%0d exp=2", nfd);
    end
  endtask

  task automatic test_stall();
    logic [11:0] e;
    int ndv = 0;
    for (int c = 0; c < 30; c++) begin
      step((c <= 5) || ((c >= 9) && (c <= 18)), 1'b0, 1'b0);
      e = {(c <= 5) || ((c >= 9) && (c <= 26)), (c >= 11) && (c <= 18),
           (c >= 12) && (c <= 27), (c >= 12) && (c <= 19),
           ((c >= 20) && (c <= 27)) ? 4'(c - 20) : 4'd0, c == 27, c == 27,
           (c >= 1) && (c <= 26), 1'b0};
      ndv += int'(dout_valid);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL stall c=%0d got=%b exp=%b", c, obs, e);
      end
    end
    n_checks++;
    if (ndv != 16) begin
      n_fail++;
      $display("FAIL stall_dout_count got=%0d exp=16", ndv);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 12'b1111_0000_0010) begin
      n_fail++;
      $display("FAIL rst_mid_before got=%b exp=%b", obs, 12'b1111_0000_0010);
    end
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== 12'd0) begin
      n_fail++;
      $display("FAIL rst_mid_after got=%b exp=%b", obs, 12'd0);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_dly1();
    logic [8:0] e;
    int ndv = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b0, c < 16);
      e = {c <= 16, (c < 16) && (c % 2 == 1), (c >= 2) && (c <= 17),
           (c >= 2) && (c <= 16) && (c % 2 == 0), 1'b0, c == 17, c == 17,
           (c >= 1) && (c <= 16), 1'b0};
      ndv += int'(dv1);
      n_checks++;
      if (obs1 !== e) begin
        n_fail++;
        $display("FAIL dly1 c=%0d got=%b exp=%b", c, obs1, e);
      end
    end
    n_checks++;
    if (ndv != 16) begin
      n_fail++;
      $display("FAIL dly1_dout_count got=%0d exp=16", ndv);
    end
  endtask

`ifdef FFT_SDF_STALL_CHK_EN
  task automatic test_stall_chk();
    int nfd = 0;
    for (int c = 0; c < 8; c++) begin
      step(c < 4, 1'b0, 1'b0);
      nfd += int'(frame_done);
    end
    step(1'b0, 1'b0, 1'b0);
    nfd += int'(frame_done);
    n_checks++;
    if (obs !== 12'b0000_0000_0001) begin
      n_fail++;
      $display("FAIL stall_abort got=%b exp=%b", obs, 12'b0000_0000_0001);
    end
    n_checks++;
    if (nfd != 0) begin
      n_fail++;
      $display("FAIL stall_abort_frame_done got=%0d exp=0", nfd);
    end
    for (int c = 0; c < 28; c++) step(c < 16, 1'b0, 1'b0);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got=%b exp=1", err);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear got=%b exp=0", err);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    din1      = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_single();
    test_dly1();
`ifdef FFT_SDF_STALL_CHK_EN
    test_stall_chk();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
